// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, branch flushes,
// data-memory wait with watchdog, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WAIT_W-1:0]  wait_next;
    logic               load_use;
    logic               mem_hold;
    logic               eval_run;
    logic               stall_inc;
    logic               flush_inc;

    // Next state, wait count and same-cycle pipeline controls
    always_comb begin
        state_next  = state;
        wait_next   = wait_cnt;
        eval_run    = 1'b0;
        flush_inc   = 1'b0;
        stall_inc   = 1'b0;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;

        // x0 is hardwired zero, so a load targeting it never creates a hazard
        load_use = ex_memread && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));
        // A dropped mem_req counts as completion so the pipe cannot lock up
        mem_hold = mem_req && !mem_ready;

        case (state)
            RUN: begin
                if (mem_hold) begin
                    state_next = MEM_WAIT;
                    wait_next  = WAIT_W'(1);
                end else begin
                    eval_run = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_hold) begin
                    state_next = RUN;
                    wait_next  = '0;
                    eval_run   = 1'b1;
                end else if (wait_cnt >= WAIT_W'(TIMEOUT - 1)) begin
                    state_next = ERR;
                end else begin
                    wait_next = wait_cnt + WAIT_W'(1);
                end
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = ERR;
            end
        endcase

        if (eval_run) begin
            if (ex_branch_taken) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                idex_write  = 1'b1;
                exmem_write = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                flush_inc   = 1'b1;
            end else if (load_use) begin
                idex_write  = 1'b1;
                exmem_write = 1'b1;
                idex_flush  = 1'b1;
            end else begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                idex_write  = 1'b1;
                exmem_write = 1'b1;
            end
        end

        stall_inc = (state != ERR) && !pc_write;

        // Reset overrides everything: pipeline held with bubbles inserted
        if (!reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end
    end

    // State, wait counter, sticky error and saturating performance counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            err       <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            err      <= err | (state_next == ERR);
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage RV64 core. It generates the PC, IF/ID, ID/EX and EX/MEM write-enables and flushes. Its inputs are ID-stage source registers, EX-stage destination/load/branch status, and the data-memory request/ready handshake. It handles load-use stalls, taken-branch flushes, and multi-cycle data-memory waits with a watchdog. It also keeps saturating stall and flush performance counters.

Parameters:
TIMEOUT, 64, max consecutive MEM_WAIT cycles before error (≥2)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_rs1  in  5  rs1 field of instruction in ID
id_rs2  in  5  rs2 field of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  destination register of instruction in EX
ex_memread  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolves a taken branch/jump
mem_req  in  1  MEM stage issuing data-memory access
mem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC register enable
ifid_write  out  1  IF/ID register enable
idex_write  out  1  ID/EX register enable
exmem_write  out  1  EX/MEM and MEM/WB enables
ifid_flush  out  1  zero IF/ID contents (bubble)
idex_flush  out  1  zero ID/EX control bits (bubble)
err  out  1  sticky memory-timeout error
stall_cnt  out  CNT_W  cycles with pc_write=0 (excluding reset/ERR)
flush_cnt  out  CNT_W  number of taken-branch flushes

Behaviour:
- States: RUN, MEM_WAIT, ERR. State is registered. Enables and flushes are combinational from state and inputs. Counters and err are registered.
- Reset asserted (reset=0), asynchronously and for as long as held:
  - state=RUN, counters=0, wait counter=0, err=0.
  - Outputs forced to pc_write=ifid_write=idex_write=exmem_write=0, ifid_flush=idex_flush=1.
- Reset mid-operation aborts any wait and clears err.
- Priority in RUN, highest first:
  - (1) mem_req=1 & mem_ready=0:
    - Freeze: all four writes=0, both flushes=0.
    - Next state MEM_WAIT, wait counter=1.
  - (2) ex_branch_taken=1:
    - All writes=1, ifid_flush=1, idex_flush=1.
    - flush_cnt+1.
  - (3) Load-use: ex_memread=1 & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)):
    - pc_write=0, ifid_write=0, idex_write=1, exmem_write=1, idex_flush=1, ifid_flush=0.
    - Exactly one bubble per hazard instance; the next cycle re-evaluates with the load in MEM.
  - (4) Otherwise all writes=1, flushes=0.
- Branch plus load-use in the same cycle: the branch wins. The ID instruction is flushed, so no stall.
- Register x0 never causes a stall.
- MEM_WAIT:
  - All writes=0, flushes=0; branch and load-use are ignored because EX is frozen and re-presents them after the wait.
  - On mem_ready=1: state→RUN. Outputs in that cycle are as RUN evaluated with mem_ready=1.
  - Otherwise wait counter+1. When the wait counter reaches TIMEOUT with mem_ready=0: state→ERR, err←1.
  - mem_req dropping in MEM_WAIT is a protocol error and is treated as mem_ready=1.
- ERR:
  - All writes=0, flushes=0, err=1.
  - Counters hold. Exit only by reset.
- stall_cnt increments in any RUN/MEM_WAIT cycle with pc_write=0.
- Both counters saturate at all-ones; no wrap.
- Zero-latency control: outputs respond in the same cycle as the inputs. Registered effects appear on the next rising edge.

Test Plan:
- Reset held 3 cycles, release → during reset: writes=0, flushes=1, counters=0. First cycle after release with quiet inputs: all writes=1, flushes=0.
- ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle → pc_write=0, ifid_write=0, idex_flush=1. stall_cnt=1 next cycle. Same stimulus with ex_rd=0 → no stall.
- Load-use hazard plus ex_branch_taken=1 in the same cycle → pc_write=1, ifid_flush=idex_flush=1, flush_cnt=1, stall_cnt unchanged.
- mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1 → writes=0 for 4 cycles, state returns to RUN on the 5th cycle with writes=1. stall_cnt=4. A branch asserted during the wait is not counted until after it.
- TIMEOUT=8, mem_req=1, mem_ready never → err=1 after 8 wait cycles, writes remain 0. Asserting reset mid-ERR clears err and the counters.
- CNT_W=4: 20 branch flushes → flush_cnt holds at 15.
